// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port RAM between the rcpu core and a DMA engine.
// Each granted request is registered onto the RAM port for one cycle (GNT), and
// the one-cycle-latency read data is routed back in the following cycle (DONE).
// Optional feature macro: MEMARB_ROUND_ROBIN_EN -- when defined, ties seen in
// IDLE go to the requester that did not win last; otherwise the CPU wins ties.
//
// Handshake: a requester raises req with addr/wdata/we and holds all of them
// stable up to and including the cycle its strobe (cpuReady / dmaAck) is high.
// The strobe is a single-cycle pulse; a new request may start the cycle after.
module mem_arbiter #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpuReq,
  input  logic [31:0]       cpuAddr,
  input  logic [DATA_W-1:0] cpuWData,
  input  logic              cpuWE,
  output logic [DATA_W-1:0] cpuRData,
  output logic              cpuReady,
  input  logic              dmaReq,
  input  logic [ADDR_W-1:0] dmaAddr,
  input  logic [DATA_W-1:0] dmaWData,
  input  logic              dmaWE,
  output logic [DATA_W-1:0] dmaRData,
  output logic              dmaAck,
  output logic [ADDR_W-1:0] ramAddr,
  output logic [DATA_W-1:0] ramWData,
  output logic              ramWE,
  input  logic [DATA_W-1:0] ramRData,
  output logic              lastGnt,
  output logic [2:0]        dbgState
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    GNT_CPU  = 3'd1,
    GNT_DMA  = 3'd2,
    DONE_CPU = 3'd3,
    DONE_DMA = 3'd4
  } state_t;

  // lastGnt encoding: 0 = CPU won most recently, 1 = DMA won most recently.
  localparam logic LAST_CPU = 1'b0;
  localparam logic LAST_DMA = 1'b1;

  state_t state;
  logic   accWrite;  // the access in flight is a write (ramWE is already cleared in DONE)
  logic   tieCpu;    // CPU takes a simultaneous request seen in IDLE

  // Upper CPU address bits are deliberately ignored (addresses wrap into the RAM).
  logic unused_cpu_addr_hi;
  assign unused_cpu_addr_hi = ^cpuAddr[31:ADDR_W];

`ifdef MEMARB_ROUND_ROBIN_EN
  // Tie goes to whoever did not win last time.
  assign tieCpu = (lastGnt == LAST_DMA);
`else
  // Fixed priority: CPU always wins a tie from IDLE.
  assign tieCpu = 1'b1;
`endif

  // Arbitration FSM plus the registered RAM drive and winner bookkeeping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      ramAddr  <= '0;
      ramWData <= '0;
      ramWE    <= 1'b0;
      accWrite <= 1'b0;
      lastGnt  <= LAST_DMA;
    end else begin
      case (state)
        IDLE: begin
          if (cpuReq && (!dmaReq || tieCpu)) begin
            state    <= GNT_CPU;
            ramAddr  <= cpuAddr[ADDR_W-1:0];
            ramWData <= cpuWData;
            ramWE    <= cpuWE;
            accWrite <= cpuWE;
            lastGnt  <= LAST_CPU;
          end else if (dmaReq) begin
            state    <= GNT_DMA;
            ramAddr  <= dmaAddr;
            ramWData <= dmaWData;
            ramWE    <= dmaWE;
            accWrite <= dmaWE;
            lastGnt  <= LAST_DMA;
          end
        end
        GNT_CPU: begin
          state <= DONE_CPU;
          ramWE <= 1'b0;
        end
        GNT_DMA: begin
          state <= DONE_DMA;
          ramWE <= 1'b0;
        end
        // The just-served CPU still shows its old request here, so only DMA is looked at.
        DONE_CPU: begin
          if (dmaReq) begin
            state    <= GNT_DMA;
            ramAddr  <= dmaAddr;
            ramWData <= dmaWData;
            ramWE    <= dmaWE;
            accWrite <= dmaWE;
            lastGnt  <= LAST_DMA;
          end else begin
            state <= IDLE;
          end
        end
        // Mirror of DONE_CPU: hand over straight to a waiting CPU.
        DONE_DMA: begin
          if (cpuReq) begin
            state    <= GNT_CPU;
            ramAddr  <= cpuAddr[ADDR_W-1:0];
            ramWData <= cpuWData;
            ramWE    <= cpuWE;
            accWrite <= cpuWE;
            lastGnt  <= LAST_CPU;
          end else begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          ramWE <= 1'b0;
        end
      endcase
    end
  end

  // Strobes and return data decode purely from the state register.
  always_comb begin
    cpuReady = (state == DONE_CPU);
    dmaAck   = (state == DONE_DMA);
    cpuRData = (cpuReady && !accWrite) ? ramRData : '0;
    dmaRData = (dmaAck && !accWrite) ? ramRData : '0;
    dbgState = state;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed, table-driven bench for mem_arbiter with a simple
// one-cycle-latency RAM model, plus a hand-written reset-in-flight sequence.
module tb_mem_arbiter;

  logic        clk;
  logic        rst;
  logic        cpuReq;
  logic [31:0] cpuAddr;
  logic [15:0] cpuWData;
  logic        cpuWE;
  logic [15:0] cpuRData;
  logic        cpuReady;
  logic        dmaReq;
  logic [15:0] dmaAddr;
  logic [15:0] dmaWData;
  logic        dmaWE;
  logic [15:0] dmaRData;
  logic        dmaAck;
  logic [15:0] ramAddr;
  logic [15:0] ramWData;
  logic        ramWE;
  logic [15:0] ramRData;
  logic        lastGnt;
  logic [2:0]  dbgState;

  int n_checks;
  int n_errors;

  mem_arbiter #(.ADDR_W(16), .DATA_W(16)) dut (
    .clk(clk), .rst(rst),
    .cpuReq(cpuReq), .cpuAddr(cpuAddr), .cpuWData(cpuWData), .cpuWE(cpuWE),
    .cpuRData(cpuRData), .cpuReady(cpuReady),
    .dmaReq(dmaReq), .dmaAddr(dmaAddr), .dmaWData(dmaWData), .dmaWE(dmaWE),
    .dmaRData(dmaRData), .dmaAck(dmaAck),
    .ramAddr(ramAddr), .ramWData(ramWData), .ramWE(ramWE), .ramRData(ramRData),
    .lastGnt(lastGnt), .dbgState(dbgState)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: write commits and read launches on the edge ending the GNT cycle.
  logic [15:0] mem [0:65535];
  always @(posedge clk) begin
    if (ramWE) mem[ramAddr] <= ramWData;
    ramRData <= mem[ramAddr];
  end

  typedef struct {
    logic        creq;
    logic [31:0] caddr;
    logic [15:0] cwd;
    logic        cwe;
    logic        dreq;
    logic [15:0] daddr;
    logic [15:0] dwd;
    logic        dwe;
    logic        e_rdy;
    logic [15:0] e_crd;
    logic        e_ack;
    logic [15:0] e_drd;
    logic        e_we;
    logic [15:0] e_addr;
    logic [15:0] e_wd;
    logic        e_lg;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(
    input logic creq, input logic [31:0] caddr, input logic [15:0] cwd, input logic cwe,
    input logic dreq, input logic [15:0] daddr, input logic [15:0] dwd, input logic dwe,
    input logic e_rdy, input logic [15:0] e_crd, input logic e_ack, input logic [15:0] e_drd,
    input logic e_we, input logic [15:0] e_addr, input logic [15:0] e_wd, input logic e_lg);
    vec_t v;
    v.creq = creq; v.caddr = caddr; v.cwd = cwd; v.cwe = cwe;
    v.dreq = dreq; v.daddr = daddr; v.dwd = dwd; v.dwe = dwe;
    v.e_rdy = e_rdy; v.e_crd = e_crd; v.e_ack = e_ack; v.e_drd = e_drd;
    v.e_we = e_we; v.e_addr = e_addr; v.e_wd = e_wd; v.e_lg = e_lg;
    return v;
  endfunction

  // scoreboard compare
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // driver
  task automatic drive(input vec_t v);
    cpuReq = v.creq; cpuAddr = v.caddr; cpuWData = v.cwd; cpuWE = v.cwe;
    dmaReq = v.dreq; dmaAddr = v.daddr; dmaWData = v.dwd; dmaWE = v.dwe;
  endtask

  task automatic idle_inputs();
    cpuReq = 1'b0; cpuAddr = '0; cpuWData = '0; cpuWE = 1'b0;
    dmaReq = 1'b0; dmaAddr = '0; dmaWData = '0; dmaWE = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    mem[16'hD000] = 16'h1234;
    rst = 1'b0;
    idle_inputs();

    // Each vector: inputs held for one cycle; expected outputs are those seen
    // just after the edge that samples them.
    //          creq caddr         cwd      cwe dreq daddr     dwd   dwe  rdy crd       ack drd       we  addr      wd        lg
    // CPU write BEEF to 0x10, then read it back
    vecs.push_back(mk(1, 32'h10, 16'hBEEF, 1, 0, 16'h0,    16'h0, 0,  0, 16'h0,    0, 16'h0,    1, 16'h10,   16'hBEEF, 0));
    vecs.push_back(mk(1, 32'h10, 16'hBEEF, 1, 0, 16'h0,    16'h0, 0,  1, 16'h0,    0, 16'h0,    0, 16'h10,   16'hBEEF, 0));
    vecs.push_back(mk(1, 32'h10, 16'hBEEF, 1, 0, 16'h0,    16'h0, 0,  0, 16'h0,    0, 16'h0,    0, 16'h10,   16'hBEEF, 0));
    vecs.push_back(mk(1, 32'h10, 16'h0,    0, 0, 16'h0,    16'h0, 0,  0, 16'h0,    0, 16'h0,    0, 16'h10,   16'h0,    0));
    vecs.push_back(mk(1, 32'h10, 16'h0,    0, 0, 16'h0,    16'h0, 0,  1, 16'hBEEF, 0, 16'h0,    0, 16'h10,   16'h0,    0));
    vecs.push_back(mk(1, 32'h10, 16'h0,    0, 0, 16'h0,    16'h0, 0,  0, 16'h0,    0, 16'h0,    0, 16'h10,   16'h0,    0));
    // DMA read of D000
    vecs.push_back(mk(0, 32'h0,  16'h0,    0, 1, 16'hD000, 16'h0, 0,  0, 16'h0,    0, 16'h0,    0, 16'hD000, 16'h0,    1));
    vecs.push_back(mk(0, 32'h0,  16'h0,    0, 1, 16'hD000, 16'h0, 0,  0, 16'h0,    1, 16'h1234, 0, 16'hD000, 16'h0,    1));
    vecs.push_back(mk(0, 32'h0,  16'h0,    0, 1, 16'hD000, 16'h0, 0,  0, 16'h0,    0, 16'h0,    0, 16'hD000, 16'h0,    1));
    // Both held: CPU, DMA, CPU, DMA with a strobe every 2 cycles
    vecs.push_back(mk(1, 32'h10, 16'h0,    0, 1, 16'hD000, 16'h0, 0,  0, 16'h0,    0, 16'h0,    0, 16'h10,   16'h0,    0));
    vecs.push_back(mk(1, 32'h10, 16'h0,    0, 1, 16'hD000, 16'h0, 0,  1, 16'hBEEF, 0, 16'h0,    0, 16'h10,   16'h0,    0));
    vecs.push_back(mk(1, 32'h10, 16'h0,    0, 1, 16'hD000, 16'h0, 0,  0, 16'h0,    0, 16'h0,    0, 16'hD000, 16'h0,    1));
    vecs.push_back(mk(1, 32'h10, 16'h0,    0, 1, 16'hD000, 16'h0, 0,  0, 16'h0,    1, 16'h1234, 0, 16'hD000, 16'h0,    1));
    vecs.push_back(mk(1, 32'h10, 16'h0,    0, 1, 16'hD000, 16'h0, 0,  0, 16'h0,    0, 16'h0,    0, 16'h10,   16'h0,    0));
    vecs.push_back(mk(1, 32'h10, 16'h0,    0, 1, 16'hD000, 16'h0, 0,  1, 16'hBEEF, 0, 16'h0,    0, 16'h10,   16'h0,    0));
    vecs.push_back(mk(1, 32'h10, 16'h0,    0, 1, 16'hD000, 16'h0, 0,  0, 16'h0,    0, 16'h0,    0, 16'hD000, 16'h0,    1));
    vecs.push_back(mk(0, 32'h0,  16'h0,    0, 1, 16'hD000, 16'h0, 0,  0, 16'h0,    1, 16'h1234, 0, 16'hD000, 16'h0,    1));
    vecs.push_back(mk(0, 32'h0,  16'h0,    0, 1, 16'hD000, 16'h0, 0,  0, 16'h0,    0, 16'h0,    0, 16'hD000, 16'h0,    1));
    // CPU write 5555 via wrapped address 0001_0005 (leaves lastGnt = CPU)
    vecs.push_back(mk(1, 32'h0001_0005, 16'h5555, 1, 0, 16'h0, 16'h0, 0, 0, 16'h0, 0, 16'h0,    1, 16'h5,    16'h5555, 0));
    vecs.push_back(mk(1, 32'h0001_0005, 16'h5555, 1, 0, 16'h0, 16'h0, 0, 1, 16'h0, 0, 16'h0,    0, 16'h5,    16'h5555, 0));
    vecs.push_back(mk(1, 32'h0001_0005, 16'h5555, 1, 0, 16'h0, 16'h0, 0, 0, 16'h0, 0, 16'h0,    0, 16'h5,    16'h5555, 0));
    // Tie from IDLE right after a CPU win
`ifdef MEMARB_ROUND_ROBIN_EN
    vecs.push_back(mk(1, 32'h5,  16'h0,    0, 1, 16'hD000, 16'h0, 0,  0, 16'h0,    0, 16'h0,    0, 16'hD000, 16'h0,    1));
    vecs.push_back(mk(1, 32'h5,  16'h0,    0, 1, 16'hD000, 16'h0, 0,  0, 16'h0,    1, 16'h1234, 0, 16'hD000, 16'h0,    1));
    vecs.push_back(mk(1, 32'h5,  16'h0,    0, 1, 16'hD000, 16'h0, 0,  0, 16'h0,    0, 16'h0,    0, 16'h5,    16'h0,    0));
    vecs.push_back(mk(1, 32'h5,  16'h0,    0, 0, 16'h0,    16'h0, 0,  1, 16'h5555, 0, 16'h0,    0, 16'h5,    16'h0,    0));
    vecs.push_back(mk(1, 32'h5,  16'h0,    0, 0, 16'h0,    16'h0, 0,  0, 16'h0,    0, 16'h0,    0, 16'h5,    16'h0,    0));
`else
    vecs.push_back(mk(1, 32'h5,  16'h0,    0, 1, 16'hD000, 16'h0, 0,  0, 16'h0,    0, 16'h0,    0, 16'h5,    16'h0,    0));
    vecs.push_back(mk(1, 32'h5,  16'h0,    0, 1, 16'hD000, 16'h0, 0,  1, 16'h5555, 0, 16'h0,    0, 16'h5,    16'h0,    0));
    vecs.push_back(mk(1, 32'h5,  16'h0,    0, 1, 16'hD000, 16'h0, 0,  0, 16'h0,    0, 16'h0,    0, 16'hD000, 16'h0,    1));
    vecs.push_back(mk(0, 32'h0,  16'h0,    0, 1, 16'hD000, 16'h0, 0,  0, 16'h0,    1, 16'h1234, 0, 16'hD000, 16'h0,    1));
    vecs.push_back(mk(0, 32'h0,  16'h0,    0, 1, 16'hD000, 16'h0, 0,  0, 16'h0,    0, 16'h0,    0, 16'hD000, 16'h0,    1));
`endif
    // CPU write 00AA via wrapped address FFFF_0007
    vecs.push_back(mk(1, 32'hFFFF_0007, 16'h00AA, 1, 0, 16'h0, 16'h0, 0, 0, 16'h0, 0, 16'h0,    1, 16'h7,    16'h00AA, 0));
    vecs.push_back(mk(1, 32'hFFFF_0007, 16'h00AA, 1, 0, 16'h0, 16'h0, 0, 1, 16'h0, 0, 16'h0,    0, 16'h7,    16'h00AA, 0));
    vecs.push_back(mk(1, 32'hFFFF_0007, 16'h00AA, 1, 0, 16'h0, 16'h0, 0, 0, 16'h0, 0, 16'h0,    0, 16'h7,    16'h00AA, 0));

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("reset ramAddr", ramAddr, 16'h0);
    chk("reset ramWData", ramWData, 16'h0);
    chk("reset ramWE", ramWE, 1'b0);
    chk("reset cpuReady", cpuReady, 1'b0);
    chk("reset dmaAck", dmaAck, 1'b0);
    chk("reset cpuRData", cpuRData, 16'h0);
    chk("reset dmaRData", dmaRData, 16'h0);
    chk("reset lastGnt", lastGnt, 1'b1);
    chk("reset state", dbgState, 3'd0);
    rst = 1'b1;

    // table-driven vectors
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i]);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d cpuReady", i), cpuReady, vecs[i].e_rdy);
      chk($sformatf("v%0d cpuRData", i), cpuRData, vecs[i].e_crd);
      chk($sformatf("v%0d dmaAck", i), dmaAck, vecs[i].e_ack);
      chk($sformatf("v%0d dmaRData", i), dmaRData, vecs[i].e_drd);
      chk($sformatf("v%0d ramWE", i), ramWE, vecs[i].e_we);
      chk($sformatf("v%0d ramAddr", i), ramAddr, vecs[i].e_addr);
      chk($sformatf("v%0d ramWData", i), ramWData, vecs[i].e_wd);
      chk($sformatf("v%0d lastGnt", i), lastGnt, vecs[i].e_lg);
    end
    idle_inputs();
    @(posedge clk);
    #1;
    chk("ram word 5", mem[16'h5], 16'h5555);
    chk("ram word 7", mem[16'h7], 16'h00AA);
    chk("ram word 10", mem[16'h10], 16'hBEEF);

    // reset pulled during GNT_CPU of a write
    cpuReq = 1'b1; cpuAddr = 32'h20; cpuWData = 16'h1111; cpuWE = 1'b1;
    @(posedge clk);
    #1;
    chk("rstgnt pre ramWE", ramWE, 1'b1);
    chk("rstgnt pre ramAddr", ramAddr, 16'h20);
    #2;
    rst = 1'b0;
    idle_inputs();
    #1;
    chk("rstgnt ramWE", ramWE, 1'b0);
    chk("rstgnt ramAddr", ramAddr, 16'h0);
    chk("rstgnt cpuReady", cpuReady, 1'b0);
    chk("rstgnt dmaAck", dmaAck, 1'b0);
    chk("rstgnt cpuRData", cpuRData, 16'h0);
    chk("rstgnt dmaRData", dmaRData, 16'h0);
    chk("rstgnt state", dbgState, 3'd0);
    @(posedge clk);
    #1;
    chk("rstgnt held cpuReady", cpuReady, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    dmaReq = 1'b1; dmaAddr = 16'hD000;
    @(posedge clk);
    #1;
    chk("resume ramAddr", ramAddr, 16'hD000);
    chk("resume lastGnt", lastGnt, 1'b1);
    chk("resume dmaAck early", dmaAck, 1'b0);
    @(posedge clk);
    #1;
    chk("resume dmaAck", dmaAck, 1'b1);
    chk("resume dmaRData", dmaRData, 16'h1234);
    chk("resume cpuReady", cpuReady, 1'b0);
    @(posedge clk);
    #1;
    chk("resume dmaAck drop", dmaAck, 1'b0);
    idle_inputs();
    repeat (2) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
